div_ratio_detect: RTL and testbench
===================================

Name: div_ratio_detect

Overview:
- Receive-side counterpart of the even clock divider.
- Samples a divided clock (or any slow periodic signal) in the fast clk_in domain and measures its period and high time in clk_in cycles.
- Declares lock once the waveform is stable and flags loss of activity.
- Used on-chip to self-check divider outputs (e.g. /2, /4, /8) and report the detected ratio to status logic.

Parameters:
- W, 8, width of period/high_time counters and outputs.
- MAX_PERIOD, 255, cycles without a rising edge before timeout; must be >= 2 and <= 2^W-1.
- LOCK_CNT, 2, consecutive identical measurements required to assert locked; must be >= 1.
- SYNC_STAGES, 0, extra flip-flops inserted on sig_in before edge detection; legal values 0 or 2. Use 0 when sig_in is generated from clk_in.

Ports:
- clk_in  input  1  sole clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- sig_in  input  1  divided clock under test, treated as data in the clk_in domain.
- period  output  W  last measured rise-to-rise distance in clk_in cycles.
- high_time  output  W  last measured count of samples with s=1 within that period.
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- locked  output  1  stable waveform detected.
- timeout  output  1  level; no rising edge for MAX_PERIOD cycles.

Behaviour:
- Reset (rst=0, async): period=0, high_time=0, meas_valid=0, locked=0, timeout=0. Also clears internal cnt, hcnt, s_prev, armed, match_cnt and sync flops.
- s = sig_in delayed by SYNC_STAGES flops (s = sig_in when 0). rise = s & ~s_prev, evaluated at each clk_in edge; s_prev <= s every cycle.
- Counters (both saturate at 2^W-1):
  - Non-rise cycle: cnt <= cnt+1; hcnt <= hcnt + s.
  - Rise cycle: cnt <= 1; hcnt <= 1.
- Measurement, rise cycle with armed=1:
  - period <= cnt; high_time <= hcnt; meas_valid <= 1 for exactly one cycle.
  - Example: s = 1,0,1,0 gives period=2, high_time=1. s = 1,1,0,0 gives 4/2.
- First rise after reset or after timeout: armed <= 1 only. No measurement, meas_valid stays 0.
- Lock:
  - On each measurement, new (period, high_time) equal to the stored pair: match_cnt <= min(match_cnt+1, LOCK_CNT).
  - Otherwise match_cnt <= 1 and locked <= 0 at the same edge.
  - locked <= 1 at the measurement edge where match_cnt reaches LOCK_CNT. The first measurement after arming counts as 1, so LOCK_CNT=1 locks on that first measurement.
- Timeout:
  - When cnt == MAX_PERIOD on a non-rise cycle: timeout <= 1, armed <= 0, locked <= 0, match_cnt <= 0.
  - period and high_time hold their last values.
  - timeout clears on the next rise; that rise only re-arms.
  - sig_in stuck at 0 or stuck at 1 both end in timeout.
- Rise on the same cycle cnt reaches MAX_PERIOD: the rise wins, normal measurement, no timeout.
- Outputs are registered; no combinational path from sig_in to any output.
- Reset mid-measurement: immediate return to reset state; measurement restarts from unarmed.

Test Plan:
- sig_in = /2 divider toggle of clk_in, SYNC_STAGES=0, LOCK_CNT=2 -> first meas_valid at the 2nd rise: period=2, high_time=1. locked=1 at the 3rd rise, stays 1.
- sig_in = /8 divided clock -> period=8, high_time=4 every 8 cycles. meas_valid is a single-cycle pulse. locked after 2 measurements.
- Lock at /4, then switch sig_in to /8 -> locked drops at the first 8/4 measurement edge. Re-locks one measurement later.
- Hold sig_in=0 after lock at /4, MAX_PERIOD=20 -> timeout=1 and locked=0 when cnt hits 20. period stays 4. Restart /4 -> timeout clears on the 1st rise, meas_valid on the 2nd.
- Duty change at fixed period: 3-high/5-low pattern -> period=8, high_time=3. Alternate with 4/4 each period -> locked never asserts.
- Assert rst for 1 cycle mid-period while locked at /2 -> all outputs 0 immediately. No meas_valid until the 2nd rise after release.

Source files
------------

// File: rtl/div_ratio_detect_if.sv
// div_ratio_detect_if: groups the divided-clock input and the measurement
// outputs of div_ratio_detect into one bundle.
//   sig_in     : slow periodic signal under test (driven by master)
//   period     : last measured rise-to-rise distance in clk_in cycles
//   high_time  : samples with s=1 within that period
//   meas_valid : one-cycle pulse when period/high_time update
//   locked     : stable waveform detected
//   timeout    : no rising edge seen for MAX_PERIOD cycles
// master = stimulus / status consumer side, slave = detector side.
interface div_ratio_detect_if #(
  parameter int W = 8
);
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  modport master (
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/div_ratio_detect.sv
// div_ratio_detect: measures period and high time of a slow periodic signal
// (typically a divided clock) in clk_in cycles, declares lock after LOCK_CNT
// identical consecutive measurements and flags loss of activity.
//   clk_in : sole clock, rising edge
//   rst    : asynchronous active-low reset
//   bus    : div_ratio_detect_if.slave (sig_in in, measurement/status out)
// All outputs come straight from flops; sig_in never reaches an output
// combinationally.
module div_ratio_detect #(
  parameter int W           = 8,
  parameter int MAX_PERIOD  = 255,
  parameter int LOCK_CNT    = 2,
  parameter int SYNC_STAGES = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  div_ratio_detect_if.slave bus
);

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  CNT_MAX   = {W{1'b1}};
  localparam logic [W-1:0]  CNT_ONE   = W'(1);
  localparam logic [W-1:0]  TMO_CNT   = W'(MAX_PERIOD);
  localparam logic [MW-1:0] LOCK_V    = MW'(LOCK_CNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);
  localparam logic [MW-1:0] MATCH_ZERO = MW'(0);

  logic s_s;
  logic rise_s;

  generate
    if (SYNC_STAGES == 2) begin : g_sync
      logic [1:0] sync_q;
      // Two-flop synchroniser for a sig_in coming from an unrelated domain
      always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
          sync_q <= 2'b00;
        end else begin
          sync_q <= {sync_q[0], bus.sig_in};
        end
      end
      assign s_s = sync_q[1];
    end else begin : g_nosync
      assign s_s = bus.sig_in;
    end
  endgenerate

  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  hcnt_q, hcnt_d;
  logic          s_prev_q;
  logic          armed_q, armed_d;
  logic [MW-1:0] match_q, match_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  high_q, high_d;
  logic          mv_q, mv_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  assign rise_s = s_s & ~s_prev_q;

  // Next-state: counters, measurement capture, lock tracking and timeout
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    armed_d   = armed_q;
    match_d   = match_q;
    period_d  = period_q;
    high_d    = high_q;
    mv_d      = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (rise_s) begin
      // The rise sample itself starts the next period and is high.
      cnt_d     = CNT_ONE;
      hcnt_d    = CNT_ONE;
      timeout_d = 1'b0;
      if (armed_q) begin
        period_d = cnt_q;
        high_d   = hcnt_q;
        mv_d     = 1'b1;
        if ((cnt_q == period_q) && (hcnt_q == high_q)) begin
          if (match_q < LOCK_V) begin
            match_d = match_q + MATCH_ONE;
          end else begin
            match_d = match_q;
          end
        end else begin
          match_d = MATCH_ONE;
        end
        locked_d = (match_d == LOCK_V);
      end else begin
        // First rise after reset/timeout only arms; no prior period exists.
        armed_d = 1'b1;
      end
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (s_s && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end else begin
        hcnt_d = hcnt_q;
      end
      // A rise on the same cycle takes priority, so this sits in the non-rise arm.
      if (cnt_q == TMO_CNT) begin
        timeout_d = 1'b1;
        armed_d   = 1'b0;
        locked_d  = 1'b0;
        match_d   = MATCH_ZERO;
      end else begin
        timeout_d = timeout_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q     <= {W{1'b0}};
      hcnt_q    <= {W{1'b0}};
      s_prev_q  <= 1'b0;
      armed_q   <= 1'b0;
      match_q   <= MATCH_ZERO;
      period_q  <= {W{1'b0}};
      high_q    <= {W{1'b0}};
      mv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      s_prev_q  <= s_s;
      armed_q   <= armed_d;
      match_q   <= match_d;
      period_q  <= period_d;
      high_q    <= high_d;
      mv_q      <= mv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = mv_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_div_ratio_detect.sv
// tb_div_ratio_detect: directed bench for div_ratio_detect with W=8,
// MAX_PERIOD=20, LOCK_CNT=2, SYNC_STAGES=0. sig_in is driven on the falling
// edge and outputs are sampled on the following falling edge, so each tick()
// shows the effect of exactly one rising clk_in edge.
module tb_div_ratio_detect;

  logic clk_in;
  logic rst;
  int   total;
  int   bad;
  logic [18:0] exp_v;

  div_ratio_detect_if #(.W(8)) bus_if ();

  div_ratio_detect #(
    .W(8), .MAX_PERIOD(20), .LOCK_CNT(2), .SYNC_STAGES(0)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_if.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // {meas_valid, locked, timeout, period, high_time}
  function automatic logic [18:0] obs();
    return {bus_if.meas_valid, bus_if.locked, bus_if.timeout, bus_if.period, bus_if.high_time};
  endfunction

  function automatic logic [18:0] pk(input logic mv, input logic lk, input logic to,
                                     input logic [7:0] p, input logic [7:0] h);
    return {mv, lk, to, p, h};
  endfunction

  task automatic tick(input logic v);
    bus_if.sig_in = v;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic rest(input int n1, input int n0);
    for (int i = 0; i < n1; i++) tick(1'b1);
    for (int i = 0; i < n0; i++) tick(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.sig_in = 1'b0;
    #2;
    exp_v = pk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs(), exp_v); end
    @(negedge clk_in);
    @(negedge clk_in);
    total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs(), exp_v); end
    rst = 1'b1;
  endtask

  task automatic test_div2();
    tick(1'b1);
    exp_v = pk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL div2_arm got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd2, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL div2_meas1 got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
    exp_v = pk(1'b0, 1'b0, 1'b0, 8'd2, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL div2_pulse got=%h exp=%h", obs(), exp_v); end
    tick(1'b1);
    exp_v = pk(1'b1, 1'b1, 1'b0, 8'd2, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL div2_lock got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
    tick(1'b1);
    total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL div2_stay got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
  endtask

  task automatic test_div8();
    logic [18:0] exp_r [3];
    logic [18:0] exp_n [3];
    exp_r[0] = pk(1'b1, 1'b1, 1'b0, 8'd2, 8'd1);  exp_n[0] = pk(1'b0, 1'b1, 1'b0, 8'd2, 8'd1);
    exp_r[1] = pk(1'b1, 1'b0, 1'b0, 8'd8, 8'd4);  exp_n[1] = pk(1'b0, 1'b0, 1'b0, 8'd8, 8'd4);
    exp_r[2] = pk(1'b1, 1'b1, 1'b0, 8'd8, 8'd4);  exp_n[2] = pk(1'b0, 1'b1, 1'b0, 8'd8, 8'd4);
    for (int p = 0; p < 3; p++) begin
      tick(1'b1);
      total++;
      if (obs() !== exp_r[p]) begin bad++; $display("FAIL div8_rise%0d got=%h exp=%h", p, obs(), exp_r[p]); end
      tick(1'b1);
      total++;
      if (obs() !== exp_n[p]) begin bad++; $display("FAIL div8_after%0d got=%h exp=%h", p, obs(), exp_n[p]); end
      rest(2, 4);
    end
  endtask

  task automatic test_div4_to_div8();
    logic [18:0] exp_r [6];
    exp_r[0] = pk(1'b1, 1'b1, 1'b0, 8'd8, 8'd4);
    exp_r[1] = pk(1'b1, 1'b0, 1'b0, 8'd4, 8'd2);
    exp_r[2] = pk(1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    exp_r[3] = pk(1'b1, 1'b1, 1'b0, 8'd4, 8'd2);
    exp_r[4] = pk(1'b1, 1'b0, 1'b0, 8'd8, 8'd4);
    exp_r[5] = pk(1'b1, 1'b1, 1'b0, 8'd8, 8'd4);
    for (int p = 0; p < 6; p++) begin
      tick(1'b1);
      total++;
      if (obs() !== exp_r[p]) begin bad++; $display("FAIL sw48_rise%0d got=%h exp=%h", p, obs(), exp_r[p]); end
      if (p < 3) rest(1, 2);
      else rest(3, 4);
    end
  endtask

  task automatic test_timeout();
    // lock at /4 coming from a locked /8 waveform
    tick(1'b1); rest(1, 2);
    tick(1'b1); rest(1, 2);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b1, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_lock got=%h exp=%h", obs(), exp_v); end
    // cnt counts 1..19 after this rise, timeout fires at the edge where cnt==20
    tick(1'b1);
    for (int i = 2; i < 20; i++) tick(1'b0);
    exp_v = pk(1'b0, 1'b1, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_before got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
    exp_v = pk(1'b0, 1'b0, 1'b1, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_fire got=%h exp=%h", obs(), exp_v); end
    rest(0, 3);
    total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_level got=%h exp=%h", obs(), exp_v); end
    // restart /4
    tick(1'b1);
    exp_v = pk(1'b0, 1'b0, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_rearm got=%h exp=%h", obs(), exp_v); end
    rest(1, 2);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_meas got=%h exp=%h", obs(), exp_v); end
    rest(1, 2);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b1, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL tmo_relock got=%h exp=%h", obs(), exp_v); end
    rest(1, 2);
  endtask

  task automatic test_rise_at_max();
    tick(1'b1);
    rest(0, 19);
    exp_v = pk(1'b0, 1'b1, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL max_before got=%h exp=%h", obs(), exp_v); end
    // rise arrives exactly when cnt==20: measurement wins over timeout
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd20, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL max_rise got=%h exp=%h", obs(), exp_v); end
    rest(1, 2);
  endtask

  task automatic test_duty();
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd4, 8'd2); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL duty_r1 got=%h exp=%h", obs(), exp_v); end
    rest(2, 5);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd8, 8'd3); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL duty_r2 got=%h exp=%h", obs(), exp_v); end
    rest(2, 5);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b1, 1'b0, 8'd8, 8'd3); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL duty_lock got=%h exp=%h", obs(), exp_v); end
    rest(3, 4);
    // alternate 4/4 and 3/5: every measurement differs from the previous one
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      exp_v = pk(1'b1, 1'b0, 1'b0, 8'd8, ((i % 2) == 0) ? 8'd4 : 8'd3); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL duty_alt%0d got=%h exp=%h", i, obs(), exp_v); end
      if ((i % 2) == 0) rest(2, 5);
      else rest(3, 4);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1); tick(1'b0);
    tick(1'b1); tick(1'b0);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b1, 1'b0, 8'd2, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL rmid_lock got=%h exp=%h", obs(), exp_v); end
    bus_if.sig_in = 1'b0;
    rst = 1'b0;
    #1;
    exp_v = pk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL rmid_async got=%h exp=%h", obs(), exp_v); end
    @(negedge clk_in);
    rst = 1'b1;
    tick(1'b0);
    tick(1'b1);
    total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL rmid_arm got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
    tick(1'b1);
    exp_v = pk(1'b1, 1'b0, 1'b0, 8'd2, 8'd1); total++;
    if (obs() !== exp_v) begin bad++; $display("FAIL rmid_meas got=%h exp=%h", obs(), exp_v); end
    tick(1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_div2();
    test_div8();
    test_div4_to_div8();
    test_timeout();
    test_rise_at_max();
    test_duty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
